// File: rtl/attn_value_accum_pkg.sv
// Shared types and Q15 helpers for the attention value-accumulate stage.
package attn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        ACC,
        WRITE,
        DONE_STATE
    } attn_state_e;

    localparam int          Q15_FRAC = 15;
    localparam logic [15:0] Q15_MAX  = 16'h7FFF;
    localparam logic [15:0] Q15_MIN  = 16'h8000;

    // Input is the already-shifted accumulator, sign-extended to 64 bits.
    function automatic logic [15:0] sat_q15(input logic signed [63:0] acc);
        if (acc > 64'sd32767)
            return Q15_MAX;
        else if (acc < -64'sd32768)
            return Q15_MIN;
        else
            return acc[15:0];
    endfunction

endpackage

// File: rtl/attn_value_accum_if.sv
// Operand/result bus of attn_value_accum; flattened element arrays, element k at [k*DATA_WIDTH +: DATA_WIDTH].
interface attn_value_accum_if #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8
);
    logic                          start;
    logic [DATA_WIDTH*L*N*L-1:0]   A_in;
    logic [DATA_WIDTH*L*N*E-1:0]   V_in;
    logic [DATA_WIDTH*L*N*E-1:0]   O_out;
    logic                          busy;
    logic                          done;
    logic                          out_valid;

    modport master (output start, A_in, V_in, input O_out, busy, done, out_valid);
    modport slave  (input start, A_in, V_in, output O_out, busy, done, out_valid);
endinterface

// File: rtl/attn_value_accum_mac.sv
// Registered Q15 multiply-accumulate (unsigned weight x signed value) with Q15 result view.
// Define ATTN_ROUND_NEAREST_EN for round-half-up instead of truncation toward -inf.
module q15_mac
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W      = 36
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_v,
    output logic [DATA_WIDTH-1:0] o_result
);
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [2*DATA_WIDTH:0] w_prod;
    logic signed [ACC_W-1:0]      w_prod_ext;
    logic signed [ACC_W-1:0]      w_adj;
    logic signed [ACC_W-1:0]      w_shift;

    // Weights are zero-extended: bit15 set never turns a weight negative.
    assign w_prod     = $signed({1'b0, i_a}) * $signed(i_v);
    assign w_prod_ext = ACC_W'(w_prod);

`ifdef ATTN_ROUND_NEAREST_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(2 ** (Q15_FRAC - 1));
    assign w_adj = r_acc + RND;
`else
    assign w_adj = r_acc;
`endif

    assign w_shift  = w_adj >>> Q15_FRAC;
    assign o_result = DATA_WIDTH'(sat_q15(64'(w_shift)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + w_prod_ext;
    end
endmodule

// File: rtl/attn_value_accum.sv
// O[i,h,e] = sum_j A[i,h,j]*V[j,h,e] computed one MAC per cycle from snapshotted operands.
// Rounding mode of the result selected by ATTN_ROUND_NEAREST_EN (see q15_mac).
module attn_value_accum
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    attn_value_accum_if.slave  bus
);
    localparam int NA    = L * N * L;
    localparam int NV    = L * N * E;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(L) + 1;
    localparam int IW    = (L > 1) ? $clog2(L) : 1;
    localparam int HW    = (N > 1) ? $clog2(N) : 1;
    localparam int EW    = (E > 1) ? $clog2(E) : 1;
    localparam int AIW   = $clog2(NA);
    localparam int VIW   = $clog2(NV);

    localparam logic [IW-1:0] I_LAST = IW'(L - 1);
    localparam logic [HW-1:0] H_LAST = HW'(N - 1);
    localparam logic [EW-1:0] E_LAST = EW'(E - 1);

    attn_state_e           r_state;
    logic [IW-1:0]         r_i, r_j;
    logic [HW-1:0]         r_h;
    logic [EW-1:0]         r_e;
    logic                  r_busy, r_done;
    logic [DATA_WIDTH-1:0] r_a [NA];
    logic [DATA_WIDTH-1:0] r_v [NV];
    logic [DATA_WIDTH-1:0] r_o [NV];
    logic [DATA_WIDTH-1:0] w_a_in [NA];
    logic [DATA_WIDTH-1:0] w_v_in [NV];
    logic [AIW-1:0]        w_a_idx;
    logic [VIW-1:0]        w_v_idx, w_o_idx;
    logic [DATA_WIDTH-1:0] w_result;

    for (genvar g = 0; g < NA; g++) begin : g_a
        assign w_a_in[g] = bus.A_in[g*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar g = 0; g < NV; g++) begin : g_vo
        assign w_v_in[g]                         = bus.V_in[g*DATA_WIDTH +: DATA_WIDTH];
        assign bus.O_out[g*DATA_WIDTH +: DATA_WIDTH] = r_o[g];
    end

    always_comb begin
        w_a_idx = AIW'((32'(r_i) * N + 32'(r_h)) * L + 32'(r_j));
        w_v_idx = VIW'((32'(r_j) * N + 32'(r_h)) * E + 32'(r_e));
        w_o_idx = VIW'((32'(r_i) * N + 32'(r_h)) * E + 32'(r_e));
    end

    q15_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    ((r_state == CAPTURE) || (r_state == WRITE)),
        .i_en     (r_state == ACC),
        .i_a      (r_a[w_a_idx]),
        .i_v      (r_v[w_v_idx]),
        .o_result (w_result)
    );

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_valid = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_h     <= '0;
            r_e     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '{default: '0};
            r_v     <= '{default: '0};
            r_o     <= '{default: '0};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_a     <= w_a_in;
                    r_v     <= w_v_in;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_h     <= '0;
                    r_e     <= '0;
                    r_state <= ACC;
                end
                ACC: begin
                    if (r_j == I_LAST)
                        r_state <= WRITE;
                    else
                        r_j <= r_j + 1'b1;
                end
                WRITE: begin
                    r_o[w_o_idx] <= w_result;
                    r_j          <= '0;
                    r_state      <= ACC;
                    // e fastest, then h, then i; the final element exits to DONE_STATE.
                    if (r_e == E_LAST) begin
                        r_e <= '0;
                        if (r_h == H_LAST) begin
                            r_h <= '0;
                            if (r_i == I_LAST)
                                r_state <= DONE_STATE;
                            else
                                r_i <= r_i + 1'b1;
                        end else begin
                            r_h <= r_h + 1'b1;
                        end
                    end else begin
                        r_e <= r_e + 1'b1;
                    end
                end
                DONE_STATE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_attn_value_accum.sv
// Scoreboard bench for attn_value_accum: default (N=1,E=8) and multi-head (N=2,E=4) instances.
module tb_attn_value_accum;
    localparam int DW = 16;
    localparam int L  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    attn_value_accum_if #(.DATA_WIDTH(DW), .L(L), .N(1), .E(8)) bus0 ();
    attn_value_accum_if #(.DATA_WIDTH(DW), .L(L), .N(2), .E(4)) bus1 ();

    attn_value_accum #(.DATA_WIDTH(DW), .L(L), .N(1), .E(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    attn_value_accum #(.DATA_WIDTH(DW), .L(L), .N(2), .E(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [15:0] a_tab [128];
    logic [15:0] v_tab [64];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] q15_model(input longint s);
        longint t;
        t = s;
`ifdef ATTN_ROUND_NEAREST_EN
        t = t + 64'sd16384;
`endif
        t = t >>> 15;
        if (t > 32767)  return 16'h7FFF;
        if (t < -32768) return 16'h8000;
        return t[15:0];
    endfunction

    task automatic push_exp(input int n, input int e);
        longint s;
        for (int i = 0; i < L; i++)
            for (int h = 0; h < n; h++)
                for (int ee = 0; ee < e; ee++) begin
                    s = 0;
                    for (int j = 0; j < L; j++)
                        s += longint'({48'b0, a_tab[(i*n+h)*L+j]}) * longint'($signed(v_tab[(j*n+h)*e+ee]));
                    exp_q.push_back(q15_model(s));
                end
    endtask

    task automatic load(input int sel);
        logic [2047:0] pa;
        logic [1023:0] pv;
        pa = '0;
        pv = '0;
        for (int k = 127; k >= 0; k--) pa = {pa[2031:0], a_tab[k]};
        for (int k = 63; k >= 0; k--)  pv = {pv[1007:0], v_tab[k]};
        if (sel == 0) begin
            bus0.A_in = pa[1023:0];
            bus0.V_in = pv;
        end else begin
            bus1.A_in = pa;
            bus1.V_in = pv;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 128; k++) a_tab[k] = 16'($urandom_range(0, 32767));
        for (int k = 0; k < 64; k++)  v_tab[k] = 16'($urandom);
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic run(input int sel, input string name, input bit scramble, input bit poke);
        int            cyc;
        int            extra;
        logic          d;
        logic [1023:0] o;
        push_exp(sel ? 2 : 1, sel ? 4 : 8);
        load(sel);
        pulse_start(sel);
        cyc = 0;
        d   = 1'b0;
        while (!d && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
            d = sel ? bus1.done : bus0.done;
            if (scramble && cyc == 2) begin
                bus0.A_in = ~bus0.A_in;
                bus0.V_in = ~bus0.V_in;
            end
            if (poke && cyc == 100) begin
                check({name, "_busy_mid"}, {31'b0, bus0.busy}, 32'd1);
                bus0.start = 1'b1;
                @(negedge clk);
                bus0.start = 1'b0;
            end
        end
        check({name, "_latency"}, cyc, 32'd578);
        check({name, "_out_valid"}, {31'b0, sel ? bus1.out_valid : bus0.out_valid}, 32'd1);
        check({name, "_busy_end"}, {31'b0, sel ? bus1.busy : bus0.busy}, 32'd0);
        o = sel ? bus1.O_out : bus0.O_out;
        for (int k = 0; k < 64; k++) begin
            if (exp_q.size() == 0)
                check($sformatf("%s_queue%0d", name, k), 32'd0, 32'd1);
            else
                check($sformatf("%s_o%0d", name, k), {16'b0, o[15:0]}, {16'b0, exp_q.pop_front()});
            o = o >> 16;
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (sel ? bus1.done : bus0.done) extra++;
        end
        check({name, "_single_done"}, extra, 32'd0);
    endtask

    initial begin
        int dones;
        rst_n      = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus0.A_in  = '0;
        bus0.V_in  = '0;
        bus1.A_in  = '0;
        bus1.V_in  = '0;
        #22;
        check("rst_o", {31'b0, |bus0.O_out}, 32'd0);
        check("rst_busy", {31'b0, bus0.busy}, 32'd0);
        check("rst_done", {31'b0, bus0.done | bus0.out_valid}, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 64; k++) begin a_tab[k] = 16'h1000; v_tab[k] = 16'h2000; end
        run(0, "uniform", 1'b0, 1'b0);

        for (int k = 0; k < 64; k++) begin
            a_tab[k] = ((k / 8) == (k % 8)) ? 16'h7FFF : 16'h0000;
            v_tab[k] = 16'h4000;
        end
        run(0, "onehot", 1'b0, 1'b0);

        for (int k = 0; k < 64; k++) begin a_tab[k] = 16'h7FFF; v_tab[k] = 16'h7FFF; end
        run(0, "sat_pos", 1'b0, 1'b0);
        for (int k = 0; k < 64; k++) v_tab[k] = 16'h8000;
        run(0, "sat_neg", 1'b0, 1'b0);

        fill_rand();
        for (int j = 0; j < L; j++) a_tab[3*L+j] = 16'h0000;
        run(0, "zero_row", 1'b0, 1'b0);

        fill_rand();
        run(0, "snapshot", 1'b1, 1'b0);

        fill_rand();
        run(0, "start_busy", 1'b0, 1'b1);

        fill_rand();
        load(0);
        pulse_start(0);
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_o", {31'b0, |bus0.O_out}, 32'd0);
        check("abort_busy", {31'b0, bus0.busy}, 32'd0);
        check("abort_done", {31'b0, bus0.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (700) begin
            @(posedge clk);
            #1;
            if (bus0.done) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        run(0, "after_abort", 1'b0, 1'b0);

        for (int i = 0; i < L; i++)
            for (int h = 0; h < 2; h++)
                for (int x = 0; x < L; x++) begin
                    a_tab[(i*2+h)*L+x] = (h == 0) ? 16'h1000 : 16'h0800;
                    if (x < 4) v_tab[(i*2+h)*4+x] = (h == 0) ? 16'h2000 : 16'h4000;
                end
        run(1, "multihead", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/attn_value_accum.md
Name: attn_value_accum

Overview:
- Downstream stage of the row-wise softmax block.
- Consumes normalized attention weights A (shape L,N,L; unsigned Q15 in 0..0x7FFF) and value matrix V (shape L,N,E; signed Q1.15).
- Produces the head outputs O[i,h,e] = sum_j A[i,h,j]*V[j,h,e] (shape L,N,E; signed Q1.15).
- Sequential, one MAC per cycle; output feeds the head-concat/output-projection stage.

Parameters:
- DATA_WIDTH, 16, element width (Q15 fixed point)
- L, 8, sequence length
- N, 1, number of attention heads
- E, 8, per-head value dimension

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin one computation; sampled only in IDLE
- A_in  input  DATA_WIDTH x L*N*L  weights; index (i*N+h)*L+j
- V_in  input  DATA_WIDTH x L*N*E  values; index (j*N+h)*E+e
- O_out  output  DATA_WIDTH x L*N*E  results; index (i*N+h)*E+e
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at completion
- out_valid  output  1  identical to done

Behaviour:
- Reset: FSM to IDLE; O_out all 0; done, out_valid, busy 0; accumulator, counters and snapshot registers 0. Reset mid-operation aborts immediately; no partial done.
- FSM states: IDLE, CAPTURE, ACC, WRITE, DONE_STATE.
- IDLE -> CAPTURE when start=1. start in any other state is ignored.
- CAPTURE (1 cycle): snapshot A_in and V_in into internal registers. Later input changes do not affect the run. Clear acc and counters i, h, e, j. Go to ACC.
- ACC (L cycles per output element): acc <= acc + $signed({1'b0,A[i,h,j]}) * $signed(V[j,h,e]); j increments each cycle. When j==L-1, go to WRITE.
- Accumulator width: 2*DATA_WIDTH+$clog2(L)+1 bits, signed; no overflow is possible.
- WRITE (1 cycle): O_out[(i*N+h)*E+e] <= sat16(acc >>> 15), arithmetic shift, truncating toward -inf.
- sat16 clamps to [0x8000, 0x7FFF].
- Also in WRITE: clear acc, set j=0, advance e, then h, then i (e fastest). After the last element, go to DONE_STATE; otherwise go back to ACC.
- DONE_STATE (1 cycle) -> IDLE. done and out_valid are registered: they are high exactly in the cycle after DONE_STATE.
- Latency: with M = L*N*E, done is high after clock edge 2+M*(L+1) counting from the edge that samples start. For the defaults this is 578 cycles.
- O_out elements are overwritten progressively during a run. They hold their values between runs.
- A weights with bit15 set are a protocol violation: they are zero-extended, never sign-extended.

Optional Feature:
- Macro: ATTN_ROUND_NEAREST_EN.
- When defined: WRITE computes sat16((acc + 2^14) >>> 15), round-half-up.
- When undefined: plain truncation as above.
- Latency is unchanged in both cases.

Decomposition:
- Package attn_pkg: state enum type, constants Q15_FRAC=15, Q15_MAX=16'h7FFF, Q15_MIN=16'h8000, and function sat_q15(acc) returning a DATA_WIDTH value.
- One sub-module, q15_mac: registered multiply-accumulate with clear and enable inputs. It holds acc and exposes the shifted/saturated result combinationally.
- The FSM, counters and snapshot registers stay in the top module.

Test Plan:
- Uniform weights: all A=0x1000 (1/8), all V=0x2000 -> every O=0x2000; done after exactly 578 cycles (defaults).
- One-hot weights: A[i,0,j]=0x7FFF if j==i else 0; V=0x4000 -> O=0x3FFF with truncation, 0x4000 with ATTN_ROUND_NEAREST_EN.
- Saturation: all A=0x7FFF with all V=0x7FFF -> O=0x7FFF; all A=0x7FFF with all V=0x8000 -> O=0x8000.
- Zero rows and snapshot: a softmax row of zeros -> corresponding O=0. Change A_in/V_in after CAPTURE -> results reflect the captured values only.
- Control robustness: start pulsed while busy -> ignored, single done pulse. rst_n low mid-ACC -> O_out=0, busy=0, no done. A fresh start then gives correct results.
- Multi-head indexing (N=2, E=4): A head0 all 0x1000, head1 all 0x0800; V head0 0x2000, head1 0x4000 -> O head0=0x2000, head1=0x2000.
